// File: rtl/common_types_pkg.sv
// Types shared across the core datapath: register-file word and register index.
package common_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    localparam regbits_t RF_ZERO_REG = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: owns the rotating priority pointer and issues at most one
// grant per cycle, starting the search at the pointer and wrapping.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         hold,
    output logic [N-1:0] gnt,
    output logic         any
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic             found;

    // Distance-ordered scan: the first valid requester at offset k from ptr wins.
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        if (!rst && !hold) begin
            for (int k = 0; k < N; k++) begin
                for (int i = 0; i < N; i++) begin
                    if (!found && req[i] && (i == ((int'(ptr) + k) % N))) begin
                        gnt[i]  = 1'b1;
                        ptr_nxt = PTR_W'((i + 1) % N);
                        found   = 1'b1;
                    end
                end
            end
        end
    end

    assign any = |gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Shares the register file write port between NUM_REQ writeback sources; the
// winning write is registered for one cycle, plus a saturating contention counter.
module writeback_arbiter
    import common_types_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*5-1:0]    req_rd,
    input  logic [NUM_REQ*32-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    hold,
    output logic                    wen,
    output logic [4:0]              wsel,
    output logic [31:0]             wdat,
    output logic [CNT_W-1:0]        conflict_cnt
);

    logic [NUM_REQ-1:0] gnt;
    logic               any;
    regbits_t           sel_rd;
    word_t              sel_data;
    logic               seen_one;
    logic               multi;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (req_valid),
        .hold (hold),
        .gnt  (gnt),
        .any  (any)
    );

    assign req_ready = gnt;

    // gnt is one-hot, so an OR-reduction of the masked lanes is the mux.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_rd   = sel_rd | req_rd[i*5 +: 5];
                sel_data = sel_data | req_data[i*32 +: 32];
            end
        end
    end

    always_comb begin
        seen_one = 1'b0;
        multi    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                if (seen_one) begin
                    multi = 1'b1;
                end
                seen_one = 1'b1;
            end
        end
    end

    // Writes to x0 still consume the grant but are kept off the write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen  <= 1'b0;
            wsel <= '0;
            wdat <= '0;
        end else begin
            wen <= any && (sel_rd != RF_ZERO_REG);
            if (any) begin
                wsel <= sel_rd;
                wdat <= sel_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (multi && !hold && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus a randomized
// run against a behavioural round-robin reference model.
module tb_writeback_arbiter;

   localparam int N       = 3;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              hold;
   logic [N-1:0]      req_valid;
   logic [N*5-1:0]    req_rd;
   logic [N*32-1:0]   req_data;
   logic [N-1:0]      req_ready;
   logic              wen;
   logic [4:0]        wsel;
   logic [31:0]       wdat;
   logic [CNT_W-1:0]  conflict_cnt;

   logic [4:0]  rd_a  [N];
   logic [31:0] dat_a [N];
   logic [31:0] rf    [32];

   int errors = 0;
   int checks = 0;

   int          m_ptr;
   int          m_cnt;
   logic        m_wen;
   logic [4:0]  m_wsel;
   logic [31:0] m_wdat;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign req_rd[g*5 +: 5]     = rd_a[g];
      assign req_data[g*32 +: 32] = dat_a[g];
   end

   writeback_arbiter #(.NUM_REQ(N), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_rd       (req_rd),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .hold         (hold),
      .wen          (wen),
      .wsel         (wsel),
      .wdat         (wdat),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clk = ~clk;

   // Register file model: latches on the falling edge, no special x0 handling.
   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      end else if (wen) begin
         rf[wsel] <= wdat;
      end
   end

   function automatic int exp_grant();
      if (rst || hold) return -1;
      for (int k = 0; k < N; k++) begin
         if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      int g;
      g = exp_grant();
      if (g < 0) return '0;
      return N'(1) << g;
   endfunction

   // Advance one clock and update the reference model from the sampled inputs.
   task automatic tick();
      int g;
      int pop;
      g   = exp_grant();
      pop = $countones(req_valid);
      @(posedge clk);
      if (rst) begin
         m_ptr = 0; m_cnt = 0; m_wen = 1'b0; m_wsel = '0; m_wdat = '0;
      end else begin
         if (g >= 0) begin
            m_wen  = (rd_a[g] != 5'd0);
            m_wsel = rd_a[g];
            m_wdat = dat_a[g];
            m_ptr  = (g + 1) % N;
         end else begin
            m_wen = 1'b0;
         end
         if (!hold && pop >= 2 && m_cnt < CNT_MAX) m_cnt++;
      end
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1; hold = 1'b0; req_valid = '0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; hold = 1'b0; req_valid = '1;
      for (int i = 0; i < N; i++) begin rd_a[i] = 5'(i + 1); dat_a[i] = 32'h100 + 32'(i); end
      for (int c = 0; c < 2; c++) begin
         #3;
         checks++;
         if (req_ready !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready got=%b want=000", req_ready);
         end
         tick();
      end
      rst = 1'b0; req_valid = '0;
      #3; tick();
      checks++;
      if (wen !== 1'b0) begin
         errors++;
         $display("FAIL reset_wen got=%b want=0", wen);
      end
      checks++;
      if (wsel !== 5'd0) begin
         errors++;
         $display("FAIL reset_wsel got=%0d want=0", wsel);
      end
      checks++;
      if (wdat !== 32'd0) begin
         errors++;
         $display("FAIL reset_wdat got=%h want=0", wdat);
      end
      checks++;
      if (conflict_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset_cnt got=%0d want=0", conflict_cnt);
      end
   endtask

   task automatic test_single();
      reset_dut();
      rd_a[1] = 5'd5; dat_a[1] = 32'hDEADBEEF; req_valid = 3'b010;
      #3;
      checks++;
      if (req_ready !== 3'b010) begin
         errors++;
         $display("FAIL single_ready got=%b want=010", req_ready);
      end
      tick();
      req_valid = '0;
      checks++;
      if (wen !== 1'b1) begin
         errors++;
         $display("FAIL single_wen got=%b want=1", wen);
      end
      checks++;
      if (wsel !== 5'd5) begin
         errors++;
         $display("FAIL single_wsel got=%0d want=5", wsel);
      end
      checks++;
      if (wdat !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL single_wdat got=%h want=deadbeef", wdat);
      end
      #5;
      checks++;
      if (rf[5] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL single_rf got=%h want=deadbeef", rf[5]);
      end
   endtask

   task automatic test_full_contention();
      logic [31:0] want_d;
      reset_dut();
      for (int i = 0; i < N; i++) begin rd_a[i] = 5'(i + 1); dat_a[i] = 32'hA000_0000 + 32'(i); end
      req_valid = '1;
      for (int c = 0; c < 6; c++) begin
         #3;
         checks++;
         if (req_ready !== (3'b001 << (c % 3))) begin
            errors++;
            $display("FAIL contention_ready c=%0d got=%b want=%b", c, req_ready, 3'b001 << (c % 3));
         end
         want_d = dat_a[c % 3];
         tick();
         checks++;
         if (wsel !== 5'((c % 3) + 1) || wdat !== want_d || wen !== 1'b1) begin
            errors++;
            $display("FAIL contention_write c=%0d got=%0d/%h want=%0d/%h", c, wsel, wdat, (c % 3) + 1, want_d);
         end
         dat_a[c % 3] = want_d + 32'h10;
      end
      req_valid = '0;
      checks++;
      if (conflict_cnt !== 4'd6) begin
         errors++;
         $display("FAIL contention_cnt got=%0d want=6", conflict_cnt);
      end
   endtask

   task automatic test_hold();
      int want_g[6]   = '{0, 1, -1, -1, 2, 0};
      int want_cnt[6] = '{1, 2, 2, 2, 3, 4};
      logic [N-1:0] want_r;
      reset_dut();
      for (int i = 0; i < N; i++) begin rd_a[i] = 5'(i + 4); dat_a[i] = 32'hB0 + 32'(i); end
      req_valid = '1;
      for (int c = 0; c < 6; c++) begin
         hold = (c == 2 || c == 3);
         want_r = (want_g[c] < 0) ? 3'b000 : (3'b001 << want_g[c]);
         #3;
         checks++;
         if (req_ready !== want_r) begin
            errors++;
            $display("FAIL hold_ready c=%0d got=%b want=%b", c, req_ready, want_r);
         end
         tick();
         checks++;
         if (wen !== (want_g[c] >= 0)) begin
            errors++;
            $display("FAIL hold_wen c=%0d got=%b want=%b", c, wen, want_g[c] >= 0);
         end
         checks++;
         if (conflict_cnt !== 4'(want_cnt[c])) begin
            errors++;
            $display("FAIL hold_cnt c=%0d got=%0d want=%0d", c, conflict_cnt, want_cnt[c]);
         end
      end
      hold = 1'b0; req_valid = '0;
   endtask

   task automatic test_x0();
      reset_dut();
      rd_a[0] = 5'd0; dat_a[0] = 32'h1234; req_valid = 3'b001;
      #3;
      checks++;
      if (req_ready !== 3'b001) begin
         errors++;
         $display("FAIL x0_ready got=%b want=001", req_ready);
      end
      tick();
      req_valid = '0;
      checks++;
      if (wen !== 1'b0) begin
         errors++;
         $display("FAIL x0_wen got=%b want=0", wen);
      end
      #5;
      checks++;
      if (rf[0] !== 32'd0) begin
         errors++;
         $display("FAIL x0_rf got=%h want=0", rf[0]);
      end
   endtask

   task automatic test_same_rd();
      reset_dut();
      rd_a[0] = 5'd7; dat_a[0] = 32'hAAAA1111;
      rd_a[1] = 5'd7; dat_a[1] = 32'hBBBB2222;
      req_valid = 3'b011;
      #3;
      checks++;
      if (req_ready !== 3'b001) begin
         errors++;
         $display("FAIL samerd_ready0 got=%b want=001", req_ready);
      end
      tick();
      req_valid = 3'b010;
      checks++;
      if (wdat !== 32'hAAAA1111) begin
         errors++;
         $display("FAIL samerd_first got=%h want=aaaa1111", wdat);
      end
      #3;
      checks++;
      if (req_ready !== 3'b010) begin
         errors++;
         $display("FAIL samerd_ready1 got=%b want=010", req_ready);
      end
      tick();
      req_valid = '0;
      checks++;
      if (wdat !== 32'hBBBB2222) begin
         errors++;
         $display("FAIL samerd_second got=%h want=bbbb2222", wdat);
      end
      #5;
      checks++;
      if (rf[7] !== 32'hBBBB2222) begin
         errors++;
         $display("FAIL samerd_rf got=%h want=bbbb2222", rf[7]);
      end
   endtask

   task automatic test_saturation();
      reset_dut();
      req_valid = '1;
      for (int c = 0; c < 20; c++) begin
         #3; tick();
         checks++;
         if (conflict_cnt !== 4'((c + 1 < 15) ? c + 1 : 15)) begin
            errors++;
            $display("FAIL sat_cnt c=%0d got=%0d want=%0d", c, conflict_cnt, (c + 1 < 15) ? c + 1 : 15);
         end
      end
      req_valid = '0;
      #3; tick();
      checks++;
      if (conflict_cnt !== 4'd15) begin
         errors++;
         $display("FAIL sat_final got=%0d want=15", conflict_cnt);
      end
   endtask

   task automatic test_reset_mid();
      reset_dut();
      for (int i = 0; i < N; i++) begin rd_a[i] = 5'(i + 9); dat_a[i] = 32'hC0 + 32'(i); end
      req_valid = '1;
      #3; tick();
      checks++;
      if (wen !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre got=%b want=1", wen);
      end
      rst = 1'b1;
      #3;
      checks++;
      if (req_ready !== 3'b000) begin
         errors++;
         $display("FAIL rstmid_ready got=%b want=000", req_ready);
      end
      tick();
      rst = 1'b0; req_valid = '0;
      checks++;
      if (wen !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_wen got=%b want=0", wen);
      end
      checks++;
      if (conflict_cnt !== 4'd0) begin
         errors++;
         $display("FAIL rstmid_cnt got=%0d want=0", conflict_cnt);
      end
   endtask

   task automatic test_random();
      int g;
      int waits[N];
      logic [N-1:0] want_r;
      reset_dut();
      for (int i = 0; i < N; i++) waits[i] = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 99) < 60) begin
               req_valid[i] = 1'b1;
               rd_a[i]      = 5'($urandom_range(0, 31));
               dat_a[i]     = $urandom;
            end
         end
         hold = ($urandom_range(0, 99) < 15);
         rst  = ($urandom_range(0, 99) < 2);
         #3;
         want_r = exp_ready();
         checks++;
         if (req_ready !== want_r) begin
            errors++;
            $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc, req_ready, want_r);
         end
         for (int i = 0; i < N; i++) begin
            if (rst) waits[i] = 0;
            else if (req_ready[i]) waits[i] = 0;
            else if (req_valid[i] && !hold) waits[i]++;
         end
         for (int i = 0; i < N; i++) begin
            checks++;
            if (waits[i] > N - 1) begin
               errors++;
               $display("FAIL rand_starve cyc=%0d req=%0d got=%0d want<=%0d", cyc, i, waits[i], N - 1);
            end
         end
         g = exp_grant();
         tick();
         for (int i = 0; i < N; i++) if (i == g) req_valid[i] = 1'b0;
         checks++;
         if (wen !== m_wen) begin
            errors++;
            $display("FAIL rand_wen cyc=%0d got=%b want=%b", cyc, wen, m_wen);
         end
         if (m_wen) begin
            checks++;
            if (wsel !== m_wsel || wdat !== m_wdat) begin
               errors++;
               $display("FAIL rand_write cyc=%0d got=%0d/%h want=%0d/%h", cyc, wsel, wdat, m_wsel, m_wdat);
            end
         end
         checks++;
         if (conflict_cnt !== 4'(m_cnt)) begin
            errors++;
            $display("FAIL rand_cnt cyc=%0d got=%0d want=%0d", cyc, conflict_cnt, m_cnt);
         end
      end
      rst = 1'b0; hold = 1'b0; req_valid = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; hold = 1'b0; req_valid = '0;
      m_ptr = 0; m_cnt = 0; m_wen = 1'b0; m_wsel = '0; m_wdat = '0;
      for (int i = 0; i < N; i++) begin rd_a[i] = '0; dat_a[i] = '0; end
      test_reset();
      test_single();
      test_full_contention();
      test_hold();
      test_x0();
      test_same_rd();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
